// File: rtl/prog_clock_divider.sv
// Runtime-programmable 50%-duty clock divider with glitch-free retune, run/stop FSM and phase re-sync.
// Optional edge strobes (rise_stb/fall_stb) are built when CLKDIV_EDGE_STROBE_EN is defined.
module prog_clock_divider #(
    parameter int                CNT_W        = 12,
    parameter logic [CNT_W-1:0]  DEFAULT_HALF = 12'h031
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             enable,
    input  logic             sync,
    input  logic             div_load,
    input  logic [CNT_W-1:0] div_value,
    output logic             clock_out,
    output logic             running,
    output logic             cfg_pending,
    output logic             rise_stb,
    output logic             fall_stb
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] counter_r;
    logic [CNT_W-1:0] counter_s;
    logic [CNT_W-1:0] half_active_r;
    logic [CNT_W-1:0] half_active_s;
    logic [CNT_W-1:0] shadow_r;
    logic [CNT_W-1:0] shadow_s;
    logic             clock_out_r;
    logic             clock_out_s;
    logic             cfg_pending_r;
    logic             cfg_pending_s;
    logic             running_r;
    logic             toggle_s;
    logic             apply_s;
    logic [CNT_W-1:0] step_cnt_s;
    logic             step_clk_s;

    // Free-running half-period step: wrap and toggle at half_active, else count up
    always_comb begin
        toggle_s   = (counter_r == half_active_r);
        step_cnt_s = counter_r + CNT_ONE;
        step_clk_s = clock_out_r;
        if (toggle_s) begin
            step_cnt_s = CNT_ZERO;
            step_clk_s = ~clock_out_r;
        end else begin
            step_cnt_s = counter_r + CNT_ONE;
            step_clk_s = clock_out_r;
        end
    end

    // Run/stop FSM with sync handling; decides when the shadow value is applied
    always_comb begin
        state_s     = state_r;
        counter_s   = counter_r;
        clock_out_s = clock_out_r;
        apply_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                counter_s   = CNT_ZERO;
                clock_out_s = 1'b0;
                apply_s     = cfg_pending_r;
                if (enable) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    if (!clock_out_r) begin
                        state_s     = ST_IDLE;
                        counter_s   = CNT_ZERO;
                        clock_out_s = 1'b0;
                    end else begin
                        // Finish the high phase so a stop never leaves a runt pulse
                        counter_s   = step_cnt_s;
                        clock_out_s = step_clk_s;
                        apply_s     = toggle_s & cfg_pending_r;
                        if (toggle_s) begin
                            state_s = ST_IDLE;
                        end else begin
                            state_s = ST_STOPPING;
                        end
                    end
                end else if (sync) begin
                    counter_s   = CNT_ZERO;
                    clock_out_s = 1'b0;
                    apply_s     = cfg_pending_r;
                end else begin
                    counter_s   = step_cnt_s;
                    clock_out_s = step_clk_s;
                    apply_s     = toggle_s & cfg_pending_r;
                end
            end
            ST_STOPPING: begin
                counter_s   = step_cnt_s;
                clock_out_s = step_clk_s;
                apply_s     = toggle_s & cfg_pending_r;
                if (enable) begin
                    state_s = ST_RUN;
                end else if (toggle_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_STOPPING;
                end
            end
            default: begin
                state_s     = ST_IDLE;
                counter_s   = CNT_ZERO;
                clock_out_s = 1'b0;
            end
        endcase
    end

    // Shadow capture and handoff; a load on the apply edge stays pending for the next boundary
    always_comb begin
        shadow_s      = shadow_r;
        half_active_s = half_active_r;
        cfg_pending_s = cfg_pending_r;
        if (apply_s) begin
            half_active_s = shadow_r;
        end else begin
            half_active_s = half_active_r;
        end
        if (div_load) begin
            shadow_s      = div_value;
            cfg_pending_s = 1'b1;
        end else if (apply_s) begin
            shadow_s      = shadow_r;
            cfg_pending_s = 1'b0;
        end else begin
            shadow_s      = shadow_r;
            cfg_pending_s = cfg_pending_r;
        end
    end

    // Core state registers with synchronous active-low reset
    always_ff @(posedge clock_in) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            counter_r     <= CNT_ZERO;
            clock_out_r   <= 1'b0;
            half_active_r <= DEFAULT_HALF;
            shadow_r      <= DEFAULT_HALF;
            cfg_pending_r <= 1'b0;
            running_r     <= 1'b0;
        end else begin
            state_r       <= state_s;
            counter_r     <= counter_s;
            clock_out_r   <= clock_out_s;
            half_active_r <= half_active_s;
            shadow_r      <= shadow_s;
            cfg_pending_r <= cfg_pending_s;
            running_r     <= (state_s != ST_IDLE);
        end
    end

    assign clock_out   = clock_out_r;
    assign running     = running_r;
    assign cfg_pending = cfg_pending_r;

`ifdef CLKDIV_EDGE_STROBE_EN
    logic rise_stb_r;
    logic fall_stb_r;

    // Edge strobes registered alongside clock_out so they coincide with its change
    always_ff @(posedge clock_in) begin
        if (!reset) begin
            rise_stb_r <= 1'b0;
            fall_stb_r <= 1'b0;
        end else begin
            rise_stb_r <= clock_out_s & ~clock_out_r;
            fall_stb_r <= ~clock_out_s & clock_out_r;
        end
    end

    assign rise_stb = rise_stb_r;
    assign fall_stb = fall_stb_r;
`else
    assign rise_stb = 1'b0;
    assign fall_stb = 1'b0;
`endif

endmodule

// File: tb/tb_prog_clock_divider.sv
// Directed self-checking bench for prog_clock_divider; expected cycle counts are hand-derived.
module tb_prog_clock_divider;

    logic        clock_in;
    logic        reset;
    logic        enable;
    logic        sync;
    logic        div_load;
    logic [11:0] div_value;
    logic        clock_out;
    logic        running;
    logic        cfg_pending;
    logic        rise_stb;
    logic        fall_stb;

    int n_checks;
    int n_fail;
    int n;
    int acc;

    prog_clock_divider #(.CNT_W(12), .DEFAULT_HALF(12'h031)) dut (
        .clock_in    (clock_in),
        .reset       (reset),
        .enable      (enable),
        .sync        (sync),
        .div_load    (div_load),
        .div_value   (div_value),
        .clock_out   (clock_out),
        .running     (running),
        .cfg_pending (cfg_pending),
        .rise_stb    (rise_stb),
        .fall_stb    (fall_stb)
    );

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int cycles);
        repeat (cycles) @(posedge clock_in);
        #1;
    endtask

    // Count cycles until clock_out reaches lvl; gives up at budget
    task automatic wait_level(input logic lvl, input int budget, output int cnt);
        cnt = 0;
        while (clock_out !== lvl && cnt < budget) begin
            tick(1);
            cnt++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        enable = 1'b0;
        tick(2);
        check_eq("rst_clock_out", clock_out, 1'b0);
        check_eq("rst_running", running, 1'b0);
        check_eq("rst_pending", cfg_pending, 1'b0);
        check_eq("rst_strobes", {rise_stb, fall_stb}, 2'b00);
        reset = 1'b1;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b0;
        enable    = 1'b0;
        sync      = 1'b0;
        div_load  = 1'b0;
        div_value = 12'h000;
        tick(1);

        // Default H=0x31: first rise 50 cycles after entering RUN, 50/50 duty
        do_reset();
        enable = 1'b1;
        wait_level(1'b1, 300, n);
        check_eq("first_rise", n, 51);
        check_eq("run_running", running, 1'b1);
`ifdef CLKDIV_EDGE_STROBE_EN
        check_eq("first_rise_stb", rise_stb, 1'b1);
`else
        check_eq("first_rise_stb_off", rise_stb, 1'b0);
`endif
        wait_level(1'b0, 300, n);
        check_eq("high_time", n, 50);
        wait_level(1'b1, 300, n);
        check_eq("low_time", n, 50);

        // Retune mid high phase, second load overrides the first
        tick(10);
        div_value = 12'h003;
        div_load  = 1'b1;
        tick(1);
        div_load  = 1'b0;
        check_eq("pending_set", cfg_pending, 1'b1);
        tick(5);
        div_value = 12'h001;
        div_load  = 1'b1;
        tick(1);
        div_load  = 1'b0;
        check_eq("pending_held", cfg_pending, 1'b1);
        wait_level(1'b0, 300, n);
        check_eq("old_high_completes", 17 + n, 50);
        check_eq("pending_cleared", cfg_pending, 1'b0);
        wait_level(1'b1, 300, n);
        check_eq("h1_low", n, 2);
        wait_level(1'b0, 300, n);
        check_eq("h1_high", n, 2);

        // Stop in the high phase: finishes the phase, then parks
        do_reset();
        enable = 1'b1;
        wait_level(1'b1, 300, n);
        tick(10);
        enable = 1'b0;
        tick(1);
        check_eq("stopping_running", running, 1'b1);
        check_eq("stopping_clock_high", clock_out, 1'b1);
        wait_level(1'b0, 300, n);
        check_eq("stop_tail", 11 + n, 50);
        check_eq("stopped_running", running, 1'b0);
        tick(120);
        check_eq("parked_clock", clock_out, 1'b0);
        check_eq("parked_running", running, 1'b0);

        // Re-enable during STOPPING: no phase disturbance, running never drops
        enable = 1'b1;
        wait_level(1'b1, 300, n);
        check_eq("restart_rise", n, 51);
        tick(10);
        enable = 1'b0;
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            if (running !== 1'b1) acc++;
        end
        enable = 1'b1;
        wait_level(1'b0, 300, n);
        check_eq("reenable_high", 15 + n, 50);
        check_eq("reenable_running_drops", acc, 0);
        check_eq("reenable_running", running, 1'b1);
        wait_level(1'b1, 300, n);
        check_eq("reenable_low", n, 50);

        // sync at counter 20 of a high phase
        tick(20);
        sync = 1'b1;
        tick(1);
        sync = 1'b0;
        check_eq("sync_clock_low", clock_out, 1'b0);
`ifdef CLKDIV_EDGE_STROBE_EN
        check_eq("sync_fall_stb", fall_stb, 1'b1);
`else
        check_eq("sync_fall_stb_off", fall_stb, 1'b0);
`endif
        wait_level(1'b1, 300, n);
        check_eq("sync_next_rise", n, 50);

        // sync while IDLE has no effect
        wait_level(1'b0, 300, n);
        enable = 1'b0;
        tick(1);
        check_eq("idle_running", running, 1'b0);
        sync = 1'b1;
        tick(1);
        sync = 1'b0;
        check_eq("idle_sync_clock", clock_out, 1'b0);
        check_eq("idle_sync_running", running, 1'b0);

        // Load H=0 in IDLE: applied next edge, then divide by 2
        div_value = 12'h000;
        div_load  = 1'b1;
        tick(1);
        div_load  = 1'b0;
        check_eq("idle_pending_set", cfg_pending, 1'b1);
        tick(1);
        check_eq("idle_pending_applied", cfg_pending, 1'b0);
        enable = 1'b1;
        wait_level(1'b1, 300, n);
        check_eq("div2_first_rise", n, 2);
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (clock_out !== ((i % 2 == 0) ? 1'b0 : 1'b1)) acc++;
        end
        check_eq("div2_toggle_errors", acc, 0);

        // Reset mid-run: outputs cleared next edge, default half restored
        reset = 1'b0;
        tick(1);
        check_eq("midrst_clock", clock_out, 1'b0);
        check_eq("midrst_running", running, 1'b0);
        check_eq("midrst_pending", cfg_pending, 1'b0);
        check_eq("midrst_strobes", {rise_stb, fall_stb}, 2'b00);
        reset = 1'b1;
        wait_level(1'b1, 300, n);
        check_eq("midrst_default_half", n, 51);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
